// File: rtl/sd_pkg.sv
// sd_pkg: state encoding, CRC width, line levels and a one-bit CRC-16 step
// shared by the SD data-block transmitter.
package sd_pkg;

    typedef enum logic [2:0] {
        IDLE,
        STRT,
        DATA,
        CRC,
        ENDB,
        BUSYW
    } sd_tx_state_t;

    localparam int   SD_CRC16_W   = 16;
    localparam logic SD_START_BIT = 1'b0;
    localparam logic SD_END_BIT   = 1'b1;

    // Value the CRC register will hold after absorbing one more bit.
    function automatic logic [SD_CRC16_W-1:0] crc16_step(
        input logic [SD_CRC16_W-1:0] crc,
        input logic                  bitval
    );
        return {crc[SD_CRC16_W-2:0], 1'b0} ^ ((bitval ^ crc[SD_CRC16_W-1]) ? 16'h1021 : 16'h0000);
    endfunction

endpackage

// File: rtl/sd_crc_16.sv
// sd_crc_16: bit-serial CRC-16-CCITT (x^16 + x^12 + x^5 + 1), zero seed,
// asynchronous clear.
module sd_crc_16 (
    input  logic        BITVAL,
    input  logic        Enable,
    input  logic        CLK,
    input  logic        RST,
    output logic [15:0] CRC
);

    logic w_inv;

    assign w_inv = BITVAL ^ CRC[15];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            CRC <= '0;
        else if (Enable)
            CRC <= {CRC[14:0], 1'b0} ^ (w_inv ? 16'h1021 : 16'h0000);
    end

endmodule

// File: rtl/sd_data_tx.sv
// sd_data_tx: single-lane SD write-path block transmitter (start, data, CRC16, end).
// Define SD_TX_BUSY_WAIT_EN to wait for the card to release DAT0 busy before DONE.
module sd_data_tx
    import sd_pkg::*;
#(
    parameter int BLK_BYTES = 512
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       START,
    input  logic [7:0] DIN,
    input  logic       DIN_VALID,
    output logic       DIN_READY,
    input  logic       DAT_IN,
    output logic       DAT_OUT,
    output logic       DAT_OE,
    output logic       SD_CLK_EN,
    output logic       BUSY,
    output logic       DONE
);

    localparam int             BW   = $clog2(BLK_BYTES + 1);
    localparam logic [BW-1:0]  LAST = BW'(BLK_BYTES - 1);

    sd_tx_state_t              r_state, w_state_nxt;
    logic                      r_stall, w_stall_nxt;
    logic [BW-1:0]             r_byte_cnt, w_byte_cnt_nxt;
    logic [2:0]                r_bit_cnt, w_bit_cnt_nxt;
    logic [3:0]                r_crc_cnt, w_crc_cnt_nxt;
    logic [7:0]                r_byte, w_byte_nxt;
    logic [SD_CRC16_W-1:0]     r_crc_sh, w_crc_sh_nxt;
    logic                      r_crc_clr;
    logic [SD_CRC16_W-1:0]     w_crc;
    logic                      w_crc_en, w_crc_rst, w_fetch, w_take;

    // A fetch is pending in STRT and on the LSB of every byte but the last;
    // state and counters hold while it stalls, so outputs hold too.
    assign w_fetch   = (r_state == STRT) || (r_state == DATA && r_bit_cnt == 3'd7 && r_byte_cnt != LAST);
    assign w_take    = w_fetch && DIN_VALID;
    assign DIN_READY = w_fetch;
    assign SD_CLK_EN = !r_stall;
    assign BUSY      = r_state != IDLE;
    assign w_crc_en  = (r_state == DATA) && !r_stall;
    assign w_crc_rst = r_crc_clr || !RST_N;

    sd_crc_16 u_crc (
        .BITVAL (r_byte[7]),
        .Enable (w_crc_en),
        .CLK    (CLK),
        .RST    (w_crc_rst),
        .CRC    (w_crc)
    );

`ifndef SD_TX_BUSY_WAIT_EN
    logic w_unused;
    assign w_unused = DAT_IN;
`endif

    always_comb begin
        w_state_nxt    = r_state;
        w_stall_nxt    = r_stall;
        w_byte_cnt_nxt = r_byte_cnt;
        w_bit_cnt_nxt  = r_bit_cnt;
        w_crc_cnt_nxt  = r_crc_cnt;
        w_byte_nxt     = r_byte;
        w_crc_sh_nxt   = r_crc_sh;
        DAT_OUT        = 1'b1;
        DAT_OE         = 1'b0;
        DONE           = 1'b0;
        case (r_state)
            IDLE: w_state_nxt = START ? STRT : IDLE;
            STRT: begin
                DAT_OE  = 1'b1;
                DAT_OUT = SD_START_BIT;
                if (w_take) begin
                    w_byte_nxt  = DIN;
                    w_state_nxt = DATA;
                    w_stall_nxt = 1'b0;
                end else begin
                    w_stall_nxt = 1'b1;
                end
            end
            DATA: begin
                DAT_OE  = 1'b1;
                DAT_OUT = r_byte[7];
                if (w_take) begin
                    w_byte_nxt     = DIN;
                    w_bit_cnt_nxt  = '0;
                    w_byte_cnt_nxt = r_byte_cnt + 1'b1;
                    w_stall_nxt    = 1'b0;
                end else if (w_fetch) begin
                    w_stall_nxt = 1'b1;
                end else begin
                    w_byte_nxt    = {r_byte[6:0], 1'b0};
                    w_bit_cnt_nxt = r_bit_cnt + 3'd1;
                    // The instance only absorbs the last bit at this edge, so
                    // the shifter is loaded with the value one step ahead.
                    if (r_bit_cnt == 3'd7) begin
                        w_state_nxt    = CRC;
                        w_byte_cnt_nxt = '0;
                        w_crc_sh_nxt   = crc16_step(w_crc, r_byte[7]);
                    end
                end
            end
            CRC: begin
                DAT_OE        = 1'b1;
                DAT_OUT       = r_crc_sh[SD_CRC16_W-1];
                w_crc_sh_nxt  = {r_crc_sh[SD_CRC16_W-2:0], 1'b0};
                w_crc_cnt_nxt = r_crc_cnt + 4'd1;
                w_state_nxt   = (r_crc_cnt == 4'd15) ? ENDB : CRC;
            end
            ENDB: begin
                DAT_OE  = 1'b1;
                DAT_OUT = SD_END_BIT;
`ifdef SD_TX_BUSY_WAIT_EN
                w_state_nxt = BUSYW;
`else
                DONE        = 1'b1;
                w_state_nxt = IDLE;
`endif
            end
`ifdef SD_TX_BUSY_WAIT_EN
            BUSYW: begin
                // The first two cycles after the end bit are ignored while the
                // card turns the line around.
                if (r_crc_cnt != 4'd2) begin
                    w_crc_cnt_nxt = r_crc_cnt + 4'd1;
                end else if (DAT_IN) begin
                    DONE          = 1'b1;
                    w_crc_cnt_nxt = '0;
                    w_state_nxt   = IDLE;
                end
            end
`endif
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state    <= IDLE;
            r_stall    <= 1'b0;
            r_byte_cnt <= '0;
            r_bit_cnt  <= '0;
            r_crc_cnt  <= '0;
            r_byte     <= '0;
            r_crc_sh   <= '0;
            r_crc_clr  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_stall    <= w_stall_nxt;
            r_byte_cnt <= w_byte_cnt_nxt;
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_crc_cnt  <= w_crc_cnt_nxt;
            r_byte     <= w_byte_nxt;
            r_crc_sh   <= w_crc_sh_nxt;
            r_crc_clr  <= (r_state == IDLE) && START;
        end
    end

endmodule

// File: tb/tb_sd_data_tx.sv
// tb_sd_data_tx: directed and randomized frames on 1-, 2- and 512-byte
// transmitters, checked against a byte-wise CRC/bitstream reference model.
module tb_sd_data_tx;

`ifdef SD_TX_BUSY_WAIT_EN
    localparam int WAITC = 11;
`else
    localparam int WAITC = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start[3], din_valid[3], dat_in[3];
    logic [7:0] din[3];
    logic       din_ready[3], dat_out[3], dat_oe[3], clk_en[3], busy[3], done[3];
    int         total = 0;
    int         bad = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        sd_data_tx #(.BLK_BYTES(g == 0 ? 1 : g == 1 ? 2 : 512)) u_dut (
            .CLK       (clk),
            .RST_N     (rst_n),
            .START     (start[g]),
            .DIN       (din[g]),
            .DIN_VALID (din_valid[g]),
            .DIN_READY (din_ready[g]),
            .DAT_IN    (dat_in[g]),
            .DAT_OUT   (dat_out[g]),
            .DAT_OE    (dat_oe[g]),
            .SD_CLK_EN (clk_en[g]),
            .BUSY      (busy[g]),
            .DONE      (done[g])
        );
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // CRC-16/XMODEM computed a byte at a time.
    function automatic logic [15:0] model_crc(input logic [7:0] b[$]);
        logic [15:0] c = '0;
        foreach (b[i]) begin
            c = c ^ {b[i], 8'h00};
            for (int j = 0; j < 8; j++)
                c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
        end
        return c;
    endfunction

    function automatic logic [5:0] outs(input int k);
        return {dat_out[k], dat_oe[k], din_ready[k], clk_en[k], busy[k], done[k]};
    endfunction

    // One block on instance k. sb/sl: byte index whose fetch is starved and for
    // how many cycles; restart_at: cycle to re-pulse START; rst_at: cycle to abort.
    task automatic frame(input int k, input logic [7:0] b[$], input int sb, input int sl,
                         input int restart_at, input int rst_at,
                         output logic [15:0] crc_o, output int lat_o);
        int          n = b.size();
        logic [15:0] mc = model_crc(b);
        bit          exp_q[$], got[$];
        int          p = 0, dropped = 0, stalls = 0, holds = 0, busy_err = 0, oe_err = 0, miss = 0, cyc = 0;
        int          e_exp = 18 + 8 * n + sl;
        int          lat_exp = e_exp + WAITC;
        logic        prev = 1'b1, r, v;
        exp_q.push_back(1'b0);
        foreach (b[i]) for (int j = 7; j >= 0; j--) exp_q.push_back(b[i][j]);
        for (int j = 15; j >= 0; j--) exp_q.push_back(mc[j]);
        exp_q.push_back(1'b1);
        crc_o = 'x;
        lat_o = -1;
        @(negedge clk);
        start[k] = 1'b1;
        din_valid[k] = 1'b1;
        din[k] = b[0];
        while (cyc < lat_exp + 40) begin
            @(negedge clk);
            cyc++;
            r = din_ready[k];
            v = !(r && p == sb && dropped < sl);
            if (!v) dropped++;
            din_valid[k] = v;
            din[k] = p < n ? b[p] : 8'h00;
            start[k] = (cyc == restart_at);
            dat_in[k] = (cyc >= e_exp + 11);
            #1;
            if (cyc == rst_at) begin
                rst_n = 1'b0;
                #1;
                chk("async_reset_outs", 32'(outs(k)), 32'b100100);
                start[k] = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            if (!clk_en[k]) begin
                stalls++;
                if (dat_out[k] !== prev) holds++;
            end else if (dat_oe[k]) begin
                got.push_back(dat_out[k]);
            end
            prev = dat_out[k];
            if (busy[k] !== 1'b1) busy_err++;
            if (dat_oe[k] !== (cyc <= e_exp)) oe_err++;
            if (r && v) p++;
            if (done[k] === 1'b1) begin
                lat_o = cyc;
                break;
            end
        end
        start[k] = 1'b0;
        for (int i = 0; i < exp_q.size() && i < got.size(); i++)
            if (got[i] !== exp_q[i]) miss++;
        if (got.size() >= 8 * n + 18)
            for (int j = 0; j < 16; j++) crc_o[15-j] = got[1 + 8 * n + j];
        chk("frame_len", got.size(), exp_q.size());
        chk("frame_bits", miss, 0);
        chk("frame_crc", crc_o, mc);
        chk("stall_cycles", stalls, sl);
        chk("stall_hold", holds, 0);
        chk("busy_during", busy_err, 0);
        chk("oe_window", oe_err, 0);
        chk("done_latency", lat_o, lat_exp);
        @(negedge clk);
        #1;
        chk("idle_after", 32'(outs(k)), 32'b100100);
    endtask

    initial begin
        logic [7:0]  q[$];
        logic [15:0] c;
        int          lat;
        for (int k = 0; k < 3; k++) begin
            start[k] = 1'b0;
            din[k] = 8'h00;
            din_valid[k] = 1'b0;
            dat_in[k] = 1'b1;
        end
        repeat (3) @(negedge clk);
        #1;
        for (int k = 0; k < 3; k++) chk("reset_outs", 32'(outs(k)), 32'b100100);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        for (int k = 0; k < 3; k++) chk("idle_outs", 32'(outs(k)), 32'b100100);

        q = {8'hFF};
        frame(0, q, -1, 0, -1, -1, c, lat);
        chk("crc_1byte_ff", c, 16'h1EF0);
        chk("lat_1byte_ff", lat, 26 + WAITC);

        q = {};
        repeat (512) q.push_back(8'hFF);
        frame(2, q, -1, 0, -1, -1, c, lat);
        chk("crc_512_ff", c, 16'h7FA1);
        chk("lat_512_ff", lat, 4114 + WAITC);

        q = {8'h00, 8'hA5};
        frame(1, q, -1, 0, -1, -1, c, lat);
        frame(1, q, 1, 3, -1, -1, c, lat);
        frame(1, q, 0, 2, -1, -1, c, lat);
        frame(1, q, -1, 0, 6, -1, c, lat);
        frame(1, q, -1, 0, 11, -1, c, lat);

        q = {8'($urandom), 8'($urandom)};
        frame(1, q, -1, 0, -1, 22, c, lat);
        frame(1, q, -1, 0, -1, -1, c, lat);

        repeat (8) begin
            q = {8'($urandom), 8'($urandom)};
            frame(1, q, int'($urandom_range(0, 1)), int'($urandom_range(0, 4)),
                  $urandom_range(0, 1) == 1 ? int'($urandom_range(2, 17)) : -1, -1, c, lat);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
